// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_io_pkg : decode constants and read-source select shared by    |
// |              the memory/IO responder. Rev 1.0                     |
// +------------------------------------------------------------------+
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_OFS_UART  = 2'd0;
    localparam logic [1:0]  IO_OFS_CNT0  = 2'd0;

    typedef enum logic [1:0] {
        RD_RAM  = 2'd0,
        RD_RX   = 2'd1,
        RD_CNT  = 2'd2,
        RD_ZERO = 2'd3
    } rd_src_e;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_io_responder_if : CPU byte memory bus (request + read data).  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface mem_io_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output rdy_in, mem_a, mem_wr, mem_dout,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, mem_a, mem_wr, mem_dout,
        output mem_din, io_buffer_full
    );
endinterface
`default_nettype wire

// File: rtl/mem_io_responder_byte_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_fifo : power-of-two byte FIFO, async reset, push on full     |
// |             accepted when a pop frees the slot. Rev 1.0           |
// +------------------------------------------------------------------+
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    push,
    input  logic [7:0]              din,
    input  logic                    pop,
    output logic [7:0]              dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; the count disambiguates full from empty.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_io_responder : byte RAM + memory-mapped UART/counter/stop.    |
// | Optional macro MEM_IO_CYCLE_CNT_EN adds cycle counter + snapshot. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              program_stop
);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic                  w_is_io;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_uart_hit;
    logic                  w_stop_wr;
    logic                  w_tx_push;
    logic [7:0]            w_tx_din;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [CW-1:0]         w_tx_count;
    logic [CW-1:0]         w_tx_count_nxt;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [ADDR_WIDTH-1:0] w_ram_a;
    rd_src_e               w_rd_src;
    rd_src_e               r_rd_src;
    logic [7:0]            w_io_byte;
    logic [7:0]            r_io_q;
    logic [7:0]            r_ram_q;
    logic                  r_stop;
    logic                  r_iobf;
    logic [13:0]           w_unused_a;
    logic [7:0]            r_ram [0:(1<<ADDR_WIDTH)-1];

    assign w_unused_a = bus.mem_a[31:18];
    assign w_is_io    = (bus.mem_a[17:16] == IO_SEL);
    assign w_rd_req   = bus.rdy_in && !bus.mem_wr;
    assign w_wr_req   = bus.rdy_in && bus.mem_wr;
    assign w_ram_a    = bus.mem_a[ADDR_WIDTH-1:0];
    assign w_uart_hit = w_is_io && (bus.mem_a[17:0] == IO_UART_ADDR);
    assign w_stop_wr  = w_wr_req && w_is_io && (bus.mem_a[17:0] == IO_CLK_ADDR);

    // The stop marker 0x00 bypasses the zero filter on the UART data port.
    assign w_tx_push  = (w_wr_req && w_uart_hit && (bus.mem_dout != 8'h00)) || w_stop_wr;
    assign w_tx_din   = w_stop_wr ? 8'h00 : bus.mem_dout;
    assign rx_ready   = w_rd_req && w_uart_hit && rx_valid;

    assign tx_valid       = !w_tx_empty;
    assign w_pop_ok       = tx_valid && tx_ready;
    assign w_push_ok      = w_tx_push && (!w_tx_full || w_pop_ok);
    assign w_tx_count_nxt = w_tx_count + CW'(w_push_ok) - CW'(w_pop_ok);

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (w_tx_push),
        .din    (w_tx_din),
        .pop    (w_pop_ok),
        .dout   (tx_data),
        .empty  (w_tx_empty),
        .full   (w_tx_full),
        .count  (w_tx_count)
    );

`ifdef MEM_IO_CYCLE_CNT_EN
    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic        w_cnt_hit;

    assign w_cnt_hit = w_is_io && (bus.mem_a[17:2] == IO_CLK_ADDR[17:2]);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt  <= '0;
            r_snap <= '0;
        end else begin
            if (!r_stop) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_rd_req && w_is_io && (bus.mem_a[17:0] == IO_CLK_ADDR)) begin
                r_snap <= r_cnt;
            end
        end
    end
`endif

    always_comb begin
        w_rd_src  = RD_ZERO;
        w_io_byte = 8'h00;
        if (!w_is_io) begin
            w_rd_src = RD_RAM;
        end else if (w_uart_hit && rx_valid) begin
            w_rd_src  = RD_RX;
            w_io_byte = rx_data;
        end
`ifdef MEM_IO_CYCLE_CNT_EN
        // Offset 0 reads live and latches; offsets 1..3 read the latched copy.
        else if (w_cnt_hit) begin
            w_rd_src  = RD_CNT;
            w_io_byte = (bus.mem_a[1:0] == IO_OFS_CNT0) ? r_cnt[7:0]
                                                        : word_byte(r_snap, bus.mem_a[1:0]);
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (w_wr_req && !w_is_io) begin
            r_ram[w_ram_a] <= bus.mem_dout;
        end
        if (w_rd_req && !w_is_io) begin
            r_ram_q <= r_ram[w_ram_a];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_src <= RD_ZERO;
            r_io_q   <= 8'h00;
            r_stop   <= 1'b0;
            r_iobf   <= 1'b0;
        end else begin
            if (w_rd_req) begin
                r_rd_src <= w_rd_src;
                r_io_q   <= w_io_byte;
            end
            if (w_stop_wr) begin
                r_stop <= 1'b1;
            end
            r_iobf <= (w_tx_count_nxt >= CW'(TX_DEPTH - 2));
        end
    end

    always_comb begin
        bus.mem_din = 8'h00;
        case (r_rd_src)
            RD_RAM:  bus.mem_din = r_ram_q;
            RD_RX:   bus.mem_din = r_io_q;
            RD_CNT:  bus.mem_din = r_io_q;
            default: bus.mem_din = 8'h00;
        endcase
    end

    assign bus.io_buffer_full = r_iobf;
    assign program_stop       = r_stop;
endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_io_responder : vector table + scoreboard bench for the     |
// | memory/IO responder. Rev 1.0                                      |
// +------------------------------------------------------------------+
module tb_mem_io_responder;
`ifdef MEM_IO_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int TX_DEPTH = 8;

    typedef struct {
        logic        rdy;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rx_ready;
    logic       program_stop;

    int         errors = 0;
    int         checks = 0;
    int         tx_pops = 0;
    logic [31:0] cyc;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    vec_t       vt[16];

    mem_io_responder_if bus ();

    mem_io_responder #(
        .ADDR_WIDTH (17),
        .TX_DEPTH   (TX_DEPTH)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .bus          (bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .program_stop (program_stop)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // TX scoreboard: every accepted handshake must match the oldest expected byte.
    always @(negedge clk) begin
        #1;
        if (!rst && tx_valid && tx_ready) begin
            tx_pops++;
            if (tx_q.size() == 0) begin
                check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    task automatic step(input logic rdy, input logic [31:0] a, input logic wr,
                        input logic [7:0] d, input logic chk, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk);
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check("mem_din", {24'h0, bus.mem_din}, {24'h0, e});
        end
        bus.rdy_in   = rdy;
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = d;
        if (chk) rd_q.push_back(exp);
        if (rdy && wr && (a[17:0] == 18'h30000) && (d != 8'h00) && (tx_q.size() < TX_DEPTH))
            tx_q.push_back(d);
        if (rdy && wr && (a[17:0] == 18'h30004) && (tx_q.size() < TX_DEPTH))
            tx_q.push_back(8'h00);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 60 && tx_q.size() != 0; k++) @(negedge clk);
        check(nm, tx_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c1;
        int          p0;
        bus.rdy_in = 1'b0; bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;

        vt[0]  = '{1'b1, 32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[2]  = '{1'b1, 32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C};
        vt[4]  = '{1'b1, 32'h0000_0020, 1'b1, 8'h77, 1'b0, 8'h00};
        vt[5]  = '{1'b1, 32'h0000_0020, 1'b0, 8'h00, 1'b1, 8'h77};
        vt[6]  = '{1'b0, 32'h0000_0020, 1'b1, 8'hFF, 1'b1, 8'h77};
        vt[7]  = '{1'b0, 32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h77};
        vt[8]  = '{1'b1, 32'h0000_0020, 1'b0, 8'h00, 1'b1, 8'h77};
        vt[9]  = '{1'b1, 32'h0000_0030, 1'b1, 8'h5A, 1'b0, 8'h00};
        vt[10] = '{1'b1, 32'h0000_0030, 1'b0, 8'h00, 1'b1, 8'h5A};
        vt[11] = '{1'b1, 32'h0002_0010, 1'b0, 8'h00, 1'b1, 8'hA5};
        vt[12] = '{1'b1, 32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[13] = '{1'b1, 32'h0000_0020, 1'b0, 8'h00, 1'b1, 8'h77};
        vt[14] = '{1'b1, 32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00};
        vt[15] = '{1'b1, 32'hFFFC_0010, 1'b0, 8'h00, 1'b1, 8'hA5};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_din", {24'h0, bus.mem_din}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_iobf", {31'h0, bus.io_buffer_full}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_stop", {31'h0, program_stop}, 32'h0);

        for (int i = 0; i < 16; i++) step(vt[i].rdy, vt[i].a, vt[i].wr, vt[i].d, vt[i].chk, vt[i].exp);
        idle();

        // RX pop: rx_ready is combinational and only while rdy_in is high
        rx_valid = 1'b1; rx_data = 8'h9E;
        step(1'b1, 32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h9E);
        #1 check("rx_ready_on", {31'h0, rx_ready}, 32'h1);
        step(1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h9E);
        #1 check("rx_ready_stall", {31'h0, rx_ready}, 32'h0);
        rx_valid = 1'b0;
        idle();

        // Coherent 4-byte counter read at counter = 0x1234
        while (cyc < 32'h1233) @(negedge clk);
        step(1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b1, CNT_EN ? 8'h34 : 8'h00);
        step(1'b1, 32'h0003_0005, 1'b0, 8'h00, 1'b1, CNT_EN ? 8'h12 : 8'h00);
        step(1'b1, 32'h0003_0006, 1'b0, 8'h00, 1'b1, 8'h00);
        step(1'b1, 32'h0003_0007, 1'b0, 8'h00, 1'b1, 8'h00);
        idle();

        // Zero filter on the UART data port
        tx_ready = 1'b1;
        p0 = tx_pops;
        step(1'b1, 32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00);
        step(1'b1, 32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00);
        step(1'b1, 32'h0003_0000, 1'b1, 8'h42, 1'b0, 8'h00);
        idle();
        wait_drain("tx_filter_drain");
        repeat (3) @(negedge clk);
        check("tx_filter_count", tx_pops - p0, 2);

        // Fill with the UART stalled: near-full after 6, 9th dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'h0003_0000, 1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
            @(posedge clk);
            #1 check($sformatf("iobf_after_push%0d", i + 1), {31'h0, bus.io_buffer_full},
                     (i >= 5) ? 32'h1 : 32'h0);
        end
        idle();
        check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
        p0 = tx_pops;
        tx_ready = 1'b1;
        wait_drain("tx_full_drain");
        repeat (3) @(negedge clk);
        check("tx_full_count", tx_pops - p0, 8);
        check("iobf_drained", {31'h0, bus.io_buffer_full}, 32'h0);

        // Program stop: marker byte, sticky flag, frozen counter
        idle();
        step(1'b1, 32'h0003_0004, 1'b1, 8'hAB, 1'b0, 8'h00);
        c1 = cyc + 32'd1;
        idle();
        check("stop_set", {31'h0, program_stop}, 32'h1);
        wait_drain("stop_marker_drain");
        repeat (5) idle();
        step(1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b1, CNT_EN ? c1[7:0] : 8'h00);
        repeat (4) idle();
        step(1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b1, CNT_EN ? c1[7:0] : 8'h00);
        step(1'b1, 32'h0003_0005, 1'b0, 8'h00, 1'b1, CNT_EN ? c1[15:8] : 8'h00);
        idle();
        idle();
        check("stop_sticky", {31'h0, program_stop}, 32'h1);

        // Reset in the middle of a drain
        tx_ready = 1'b0;
        step(1'b1, 32'h0003_0000, 1'b1, 8'h61, 1'b0, 8'h00);
        step(1'b1, 32'h0003_0000, 1'b1, 8'h62, 1'b0, 8'h00);
        step(1'b1, 32'h0003_0000, 1'b1, 8'h63, 1'b0, 8'h00);
        idle();
        tx_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        tx_q.delete();
        rd_q.delete();
        #1;
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_stop", {31'h0, program_stop}, 32'h0);
        check("midrst_iobf", {31'h0, bus.io_buffer_full}, 32'h0);
        check("midrst_mem_din", {24'h0, bus.mem_din}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle();
        check("postrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        step(1'b1, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00);
        c1 = cyc;
        if (CNT_EN) rd_q.push_back(c1[7:0]);
        else        rd_q.push_back(8'h00);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
